sprite_anim_mapper: RTL and testbench

Parametrised sprite pixel mapper, successor to the fixed 30-pixel-wide single-frame sprite mappers. Given the VGA scan position, it computes the sprite ROM address relative to a movable top-left origin, supports multi-frame animation stepped by vertical sync and horizontal mirroring, and returns palette RGB plus a per-pixel opacity flag. It sits between the VGA controller and the frame compositor, one instance per sprite. The sprite ROM and palette stay external.

---
 rtl/sprite_anim_mapper_if.sv | 42 ++++
 rtl/sprite_anim_mapper.sv | 166 ++++++++++++++++
 tb/tb_sprite_anim_mapper.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_anim_mapper_if.sv
`default_nettype none
// ============================================================================
// Module   : sprite_anim_mapper_if
// Purpose  : Bundles the sprite mapper's connection to its external sprite
//            ROM and palette lookup.
// Ports    : rom_address  mapper -> ROM     ROM read address (1-cycle read)
//            rom_q        ROM    -> mapper  palette index read from the ROM
//            pal_index    mapper -> palette palette lookup index (= rom_q)
//            pal_red/green/blue  palette -> mapper  4-bit colour components
// Modports : master = mapper side, slave = ROM/palette side
// Revision : 1.0  initial release
// ============================================================================
interface sprite_anim_mapper_if #(
  parameter int ADDR_W = 12,
  parameter int IDX_W  = 5
);
  logic [ADDR_W-1:0] rom_address;
  logic [IDX_W-1:0]  rom_q;
  logic [IDX_W-1:0]  pal_index;
  logic [3:0]        pal_red;
  logic [3:0]        pal_green;
  logic [3:0]        pal_blue;

  modport master (
    output rom_address,
    output pal_index,
    input  rom_q,
    input  pal_red,
    input  pal_green,
    input  pal_blue
  );

  modport slave (
    input  rom_address,
    input  pal_index,
    output rom_q,
    output pal_red,
    output pal_green,
    output pal_blue
  );
endinterface
`default_nettype wire

// File: rtl/sprite_anim_mapper.sv
`default_nettype none
// ============================================================================
// Module   : sprite_anim_mapper
// Purpose  : Maps the VGA scan position onto a movable, mirrorable,
//            multi-frame sprite. Produces the sprite ROM address, then turns
//            the returned palette colour into a registered pixel colour and
//            an opacity flag. One instance per sprite.
// Ports    : vga_clk     pixel clock, rising edge
//            reset_n     asynchronous active-low reset
//            DrawX/DrawY current scan column/row
//            blank       1 = active video
//            vsync       active-low vertical sync pulse
//            sprite_x/y  requested top-left position (latched at vsync)
//            flip_h      requested horizontal mirror (latched at vsync)
//            anim_en     1 = animation advances on vsync
//            bus         ROM / palette connection (master modport)
//            red/green/blue  registered pixel colour
//            pixel_hit   registered, 1 = opaque sprite pixel
//            frame_sel   current animation frame
// Revision : 1.0  initial release
// ============================================================================
module sprite_anim_mapper #(
  parameter int SPR_W       = 30,
  parameter int SPR_H       = 30,
  parameter int FRAMES      = 4,
  parameter int FRAME_TICKS = 8,
  parameter int IDX_W       = 5,
  parameter int TRANSP_IDX  = 0,
  parameter int ADDR_W      = $clog2(FRAMES * SPR_W * SPR_H),
  localparam int FS_W       = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
  input  wire logic           vga_clk,
  input  wire logic           reset_n,
  input  wire logic [9:0]     DrawX,
  input  wire logic [9:0]     DrawY,
  input  wire logic           blank,
  input  wire logic           vsync,
  input  wire logic [9:0]     sprite_x,
  input  wire logic [9:0]     sprite_y,
  input  wire logic           flip_h,
  input  wire logic           anim_en,
  sprite_anim_mapper_if.master bus,
  output logic [3:0]          red,
  output logic [3:0]          green,
  output logic [3:0]          blue,
  output logic                pixel_hit,
  output logic [FS_W-1:0]     frame_sel
);

  localparam int TK_W     = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
  localparam int FRAME_SZ = SPR_W * SPR_H;

  // --------------------------------------------------------------------------
  // vsync falling-edge detect. The registered copy resets high so that a
  // vsync already low when reset releases counts as a fresh edge.
  // --------------------------------------------------------------------------
  logic vsync_q;
  logic vs_fall;

  assign vs_fall = vsync_q & ~vsync;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      vsync_q <= 1'b1;
    end else begin
      vsync_q <= vsync;
    end
  end

  // --------------------------------------------------------------------------
  // Shadow position/mirror: only updated between frames to avoid tearing.
  // --------------------------------------------------------------------------
  logic [9:0] pos_x;
  logic [9:0] pos_y;
  logic       flip;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      pos_x <= '0;
      pos_y <= '0;
      flip  <= 1'b0;
    end else if (vs_fall) begin
      pos_x <= sprite_x;
      pos_y <= sprite_y;
      flip  <= flip_h;
    end
  end

  // --------------------------------------------------------------------------
  // Animation: tick counts vsync edges, frame steps when tick wraps.
  // --------------------------------------------------------------------------
  logic [TK_W-1:0] tick;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      tick      <= '0;
      frame_sel <= '0;
    end else if (vs_fall && anim_en) begin
      if (tick == TK_W'(FRAME_TICKS - 1)) begin
        tick <= '0;
        if (frame_sel == FS_W'(FRAMES - 1)) begin
          frame_sel <= '0;
        end else begin
          frame_sel <= frame_sel + 1'b1;
        end
      end else begin
        tick <= tick + 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // In-box test and address. Done at 11 bits so pos+SPR_W never wraps past
  // 1023 and a sprite near the right edge cannot alias onto column 0.
  // --------------------------------------------------------------------------
  logic [10:0]       x11, y11, px11, py11;
  logic [10:0]       lx, ly, col;
  logic              in_x, in_y, in_box;
  logic [ADDR_W-1:0] addr_calc;

  always_comb begin
    x11    = {1'b0, DrawX};
    y11    = {1'b0, DrawY};
    px11   = {1'b0, pos_x};
    py11   = {1'b0, pos_y};
    in_x   = (x11 >= px11) && (x11 < px11 + 11'(SPR_W));
    in_y   = (y11 >= py11) && (y11 < py11 + 11'(SPR_H));
    in_box = in_x && in_y;
    lx     = x11 - px11;
    ly     = y11 - py11;
    col    = flip ? (11'(SPR_W - 1) - lx) : lx;
    addr_calc = ADDR_W'(frame_sel) * ADDR_W'(FRAME_SZ)
              + ADDR_W'(ly) * ADDR_W'(SPR_W)
              + ADDR_W'(col);
  end

  assign bus.rom_address = in_box ? addr_calc : '0;
  assign bus.pal_index   = bus.rom_q;

  // --------------------------------------------------------------------------
  // Stage 1 lines up the visibility flag with the ROM's one-cycle read.
  // Stage 2 applies transparency and registers the final colour.
  // --------------------------------------------------------------------------
  logic stage1;
  logic opaque;

  assign opaque = stage1 && (bus.rom_q != IDX_W'(TRANSP_IDX));

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      stage1    <= 1'b0;
      pixel_hit <= 1'b0;
      red       <= '0;
      green     <= '0;
      blue      <= '0;
    end else begin
      stage1    <= in_box & blank;
      pixel_hit <= opaque;
      red       <= opaque ? bus.pal_red   : 4'h0;
      green     <= opaque ? bus.pal_green : 4'h0;
      blue      <= opaque ? bus.pal_blue  : 4'h0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sprite_anim_mapper.sv
`default_nettype none
// ============================================================================
// Module   : tb_sprite_anim_mapper
// Purpose  : Self-checking bench for sprite_anim_mapper with a behavioural
//            sprite ROM and palette and a reference model of the mapping.
// Revision : 1.0  initial release
// ============================================================================
module tb_sprite_anim_mapper;

  logic       vga_clk;
  logic       reset_n;
  logic [9:0] DrawX, DrawY;
  logic       blank, vsync;
  logic [9:0] sprite_x, sprite_y;
  logic       flip_h, anim_en;
  logic [3:0] red, green, blue;
  logic       pixel_hit;
  logic [1:0] frame_sel;

  sprite_anim_mapper_if #(.ADDR_W(12), .IDX_W(5)) bus ();

  sprite_anim_mapper dut (
    .vga_clk  (vga_clk),
    .reset_n  (reset_n),
    .DrawX    (DrawX),
    .DrawY    (DrawY),
    .blank    (blank),
    .vsync    (vsync),
    .sprite_x (sprite_x),
    .sprite_y (sprite_y),
    .flip_h   (flip_h),
    .anim_en  (anim_en),
    .bus      (bus.master),
    .red      (red),
    .green    (green),
    .blue     (blue),
    .pixel_hit(pixel_hit),
    .frame_sel(frame_sel)
  );

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  // ROM contents and palette: simple reversible patterns.
  function automatic logic [4:0] romf(input logic [11:0] a);
    return a[4:0] ^ 5'd21;
  endfunction

  function automatic logic [11:0] palf(input logic [4:0] i);
    return {i[3:0], ~i[3:0], i[4], i[2:0]};
  endfunction

  always @(posedge vga_clk) bus.rom_q <= romf(bus.rom_address);
  assign {bus.pal_red, bus.pal_green, bus.pal_blue} = palf(bus.pal_index);

  // --------------------------------------------------------------------------
  // Checking and scoreboard
  // --------------------------------------------------------------------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
    end
  endtask

  typedef struct {
    logic        hit;
    logic [11:0] rgb;
  } exp_t;

  exp_t sb[$];

  // Reference model state
  int   m_px, m_py, m_frame, m_tick;
  logic m_flip, m_vs_prev;

  task automatic model_reset();
    m_px = 0; m_py = 0; m_frame = 0; m_tick = 0;
    m_flip = 1'b0; m_vs_prev = 1'b1;
    sb.delete();
  endtask

  // One pixel clock: compare the output due now, drive the new inputs,
  // check the combinational address, queue the expected pixel, then advance
  // the model as the DUT will on the coming edge.
  task automatic step(input int x, input int y, input logic b, input logic vs);
    exp_t e;
    int   eaddr, lx;
    logic inb;
    @(negedge vga_clk);
    check_eq("frame_sel", frame_sel, m_frame);
    if (sb.size() == 2) begin
      e = sb.pop_front();
      check_eq("pixel_hit", pixel_hit, e.hit);
      check_eq("rgb", {red, green, blue}, e.rgb);
    end
    DrawX = 10'(x); DrawY = 10'(y); blank = b; vsync = vs;
    #1;
    inb = (x >= m_px) && (x < m_px + 30) && (y >= m_py) && (y < m_py + 30);
    lx  = x - m_px;
    eaddr = inb ? (m_frame * 900 + (y - m_py) * 30 + (m_flip ? 29 - lx : lx)) : 0;
    check_eq("rom_address", bus.rom_address, eaddr);
    e.hit = inb && b && (romf(12'(eaddr)) != 5'd0);
    e.rgb = e.hit ? palf(romf(12'(eaddr))) : 12'h000;
    sb.push_back(e);
    if (m_vs_prev && !vs) begin
      m_px = sprite_x; m_py = sprite_y; m_flip = flip_h;
      if (anim_en) begin
        if (m_tick == 7) begin
          m_tick  = 0;
          m_frame = (m_frame == 3) ? 0 : m_frame + 1;
        end else begin
          m_tick++;
        end
      end
    end
    m_vs_prev = vs;
  endtask

  task automatic vs_pulse(input int n);
    for (int i = 0; i < n; i++) begin
      step(0, 0, 1'b0, 1'b0);
      step(0, 0, 1'b0, 1'b0);   // held low: still a single edge
      step(0, 0, 1'b0, 1'b1);
    end
  endtask

  task automatic set_pos(input int x, input int y, input logic f);
    sprite_x = 10'(x); sprite_y = 10'(y); flip_h = f;
    vs_pulse(1);
  endtask

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    reset_n = 1'b0; DrawX = '0; DrawY = '0; blank = 1'b0; vsync = 1'b1;
    sprite_x = '0; sprite_y = '0; flip_h = 1'b0; anim_en = 1'b0;
    model_reset();
    repeat (3) @(negedge vga_clk);
    check_eq("reset_rgb", {red, green, blue}, 0);
    check_eq("reset_hit", pixel_hit, 0);
    check_eq("reset_frame", frame_sel, 0);
    reset_n = 1'b1;

    // Basic placement, no mirror
    set_pos(100, 50, 1'b0);
    step(100, 50, 1'b1, 1'b1);
    check_eq("origin_addr", bus.rom_address, 0);
    step(129, 51, 1'b1, 1'b1);
    check_eq("addr_59", bus.rom_address, 59);
    step(99, 50, 1'b1, 1'b1);     // left of box
    step(130, 50, 1'b1, 1'b1);    // right of box
    step(121, 50, 1'b1, 1'b1);    // address 21 holds the transparent index
    step(101, 50, 1'b0, 1'b1);    // blanked inside box
    step(110, 79, 1'b1, 1'b1);    // bottom row
    step(110, 80, 1'b1, 1'b1);    // below box

    // Mirrored
    set_pos(100, 50, 1'b1);
    step(100, 50, 1'b1, 1'b1);
    check_eq("flip_origin", bus.rom_address, 29);
    step(129, 50, 1'b1, 1'b1);
    check_eq("flip_right", bus.rom_address, 0);
    step(107, 52, 1'b1, 1'b1);

    // Right-edge placement: 11-bit compare must not wrap
    set_pos(1000, 0, 1'b0);
    step(1023, 0, 1'b1, 1'b1);
    check_eq("edge_col23", bus.rom_address, 23);
    step(5, 0, 1'b1, 1'b1);
    step(1010, 29, 1'b1, 1'b1);

    // Tearing: position change only lands at vsync
    set_pos(100, 50, 1'b0);
    sprite_x = 10'd200;
    step(100, 50, 1'b1, 1'b1);
    check_eq("no_tear", bus.rom_address, 0);
    step(105, 50, 1'b1, 1'b0);    // vsync edge with pixel in flight: old origin
    step(105, 50, 1'b1, 1'b1);    // new origin now applies
    step(200, 50, 1'b1, 1'b1);
    check_eq("moved_origin", bus.rom_address, 0);

    // Animation
    anim_en = 1'b1;
    vs_pulse(8);
    check_eq("frame_after8", frame_sel, 1);
    step(200, 50, 1'b1, 1'b1);
    check_eq("frame1_addr", bus.rom_address, 900);
    step(229, 79, 1'b1, 1'b1);
    vs_pulse(24);
    check_eq("frame_wrap", frame_sel, 0);
    anim_en = 1'b0;
    vs_pulse(8);
    check_eq("frame_hold", frame_sel, 0);

    // Asynchronous reset mid-line
    anim_en = 1'b1;
    vs_pulse(16);
    step(210, 60, 1'b1, 1'b1);
    step(211, 60, 1'b1, 1'b1);
    step(212, 60, 1'b1, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("async_rgb", {red, green, blue}, 0);
    check_eq("async_hit", pixel_hit, 0);
    check_eq("async_frame", frame_sel, 0);
    model_reset();
    @(negedge vga_clk);
    reset_n = 1'b1;
    step(5, 5, 1'b1, 1'b1);       // origin 0,0 after reset
    step(6, 7, 1'b1, 1'b1);
    set_pos(300, 200, 1'b1);
    step(300, 200, 1'b1, 1'b1);
    step(315, 210, 1'b1, 1'b1);
    step(0, 0, 1'b0, 1'b1);
    step(0, 0, 1'b0, 1'b1);
    step(0, 0, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
